// File: rtl/mem_pkg.sv
// mem_pkg: shared types and helpers for the MEM-stage data-memory responder.
//   state_t    - responder FSM encoding (IDLE/BUSY/DONE)
//   WORD_W     - memory word width in bits
//   CNT_W      - latency down-counter width
//   latency_ok - legality check for the LATENCY parameter (1..15)
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WORD_W = 16;
    localparam int CNT_W  = 4;

    function automatic bit latency_ok(input int lat);
        return lat >= 1 && lat <= 15;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: synchronous single-port word array with registered read.
//   clk   - clock
//   we    - write enable, writes wdata to mem[idx] at the rising edge
//   re    - read enable, captures mem[idx] into rdata at the rising edge
//   idx   - word index
//   wdata - write data
//   rdata - registered read data (holds until the next enabled read)
module dmem_array
    import mem_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    // Contents are deliberately not reset.
    logic [WORD_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
        if (re) rdata <= mem[idx];
    end

endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: fixed-latency data-memory responder for the MEM stage.
//   clk     - clock, all state updates on the rising edge
//   rst     - asynchronous active-low reset
//   Addr    - byte address; bit 0 must be 0, word index is Addr[AW:1]
//   DataIn  - store data
//   Rd, Wr  - load / store request (exactly one may be high)
//   DataOut - load data, valid while Done is high
//   Done    - one-cycle completion pulse
//   Stall   - high from request acceptance until the cycle before Done
//   Err     - one-cycle pulse the cycle after an illegal request
module data_mem_resp
    import mem_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int AW      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       Addr,
    input  logic [15:0]       DataIn,
    input  logic              Rd,
    input  logic              Wr,
    output logic [15:0]       DataOut,
    output logic              Done,
    output logic              Stall,
    output logic              Err
);

    if (!latency_ok(LATENCY)) begin : g_bad_latency
        $error("data_mem_resp: LATENCY must be in 1..15");
    end

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [AW-1:0]      idx_q;
    logic [WORD_W-1:0]  data_q;
    logic               op_wr_q;
    logic               err_q;
    logic               req, bad, accept;
    logic               mem_we, mem_re;
    logic [AW-1:0]      mem_idx;
    logic [WORD_W-1:0]  mem_rdata;
    logic               unused_addr;

    // Bits above the word index are intentionally ignored (address wraps).
    assign unused_addr = ^Addr;

    assign req    = Rd | Wr;
    assign bad    = req & ((Rd & Wr) | Addr[0]);
    assign accept = (state == IDLE) & req & ~bad;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = (LATENCY == 1) ? DONE : BUSY;
                    cnt_nx   = (LATENCY == 1) ? '0 : CNT_W'(LATENCY - 1);
                end
            end
            BUSY: begin
                cnt_nx   = cnt - 1'b1;
                state_nx = (cnt == 1) ? DONE : BUSY;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            op_wr_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            err_q <= (state == IDLE) & bad;
            if (accept) begin
                idx_q   <= Addr[AW:1];
                data_q  <= DataIn;
                op_wr_q <= Wr;
            end
        end
    end

    // In IDLE the live address feeds the array so LATENCY=1 loads can read
    // on the accepting edge; afterwards the latched index is used.
    assign mem_idx = (state == IDLE) ? Addr[AW:1] : idx_q;
    // Read on the edge entering DONE so the data is stable throughout DONE.
    assign mem_re  = (state_nx == DONE) & (state != DONE) & ((state == IDLE) ? Rd : ~op_wr_q);
    // Store commits on the edge that ends DONE; a reset before then drops it.
    assign mem_we  = (state == DONE) & op_wr_q;

    dmem_array #(.AW(AW)) u_array (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .idx   (mem_idx),
        .wdata (data_q),
        .rdata (mem_rdata)
    );

    assign Done    = (state == DONE);
    assign DataOut = (Done & ~op_wr_q) ? mem_rdata : '0;
    assign Stall   = accept | (state == BUSY);
    assign Err     = err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: scoreboard bench for data_mem_resp at LATENCY 4, 1 and 15.
module tb_data_mem_resp;

    typedef struct {
        int          d;
        int          cyc;
        bit          err;
        bit          rd;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    exp_t        q[$];
    exp_t        me;
    logic [15:0] model [3][1024];

    logic [15:0] addr_i [3];
    logic [15:0] din_i  [3];
    logic        rd_i   [3];
    logic        wr_i   [3];
    logic [15:0] dout_o [3];
    logic        done_o [3];
    logic        stall_o[3];
    logic        err_o  [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_resp #(.LATENCY(g == 0 ? 4 : g == 1 ? 1 : 15), .AW(10)) u_dut (
            .clk     (clk),
            .rst     (rst),
            .Addr    (addr_i[g]),
            .DataIn  (din_i[g]),
            .Rd      (rd_i[g]),
            .Wr      (wr_i[g]),
            .DataOut (dout_o[g]),
            .Done    (done_o[g]),
            .Stall   (stall_o[g]),
            .Err     (err_o[g])
        );
    end

    function automatic int lat(input int d);
        return d == 0 ? 4 : d == 1 ? 1 : 15;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Completion monitor: every Done/Err must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 3; d++) begin
                if (done_o[d] || err_o[d]) begin
                    if (q.size() == 0 || q[0].d != d) begin
                        check("spurious", {30'd0, done_o[d], err_o[d]}, 32'd0);
                    end else begin
                        me = q.pop_front();
                        check("evt_cyc", cyc, me.cyc);
                        check("evt_kind", {30'd0, done_o[d], err_o[d]}, me.err ? 32'd1 : 32'd2);
                        if (!me.err) begin
                            check("stall_done", {31'd0, stall_o[d]}, 32'd0);
                            if (me.rd) check("rdata", {16'd0, dout_o[d]}, {16'd0, me.data});
                        end
                    end
                end
            end
        end
    end

    // Called just after a rising edge; returns just after a rising edge.
    task automatic issue(input int d, input logic rd, input logic wr,
                         input logic [15:0] a, input logic [15:0] din, input bit wiggle);
        exp_t e;
        bit   legal;
        int   w;
        legal = (rd ^ wr) && !a[0];
        rd_i[d] = rd; wr_i[d] = wr; addr_i[d] = a; din_i[d] = din;
        e.d    = d;
        e.err  = !legal;
        e.rd   = rd;
        e.cyc  = cyc + (legal ? lat(d) : 1);
        e.data = (legal && rd) ? model[d][a[10:1]] : 16'h0;
        if (legal && wr) model[d][a[10:1]] = din;
        q.push_back(e);
        if (legal) begin
            for (int k = 0; k < lat(d); k++) begin
                @(negedge clk);
                check("stall_busy", {31'd0, stall_o[d]}, 32'd1);
                @(posedge clk); #1;
                if (wiggle) begin
                    addr_i[d] = a ^ 16'h0002;
                    din_i[d]  = ~din;
                end
            end
        end else begin
            @(negedge clk);
            check("stall_err", {31'd0, stall_o[d]}, 32'd0);
            @(posedge clk); #1;
        end
        rd_i[d] = 1'b0;
        wr_i[d] = 1'b0;
        w = 0;
        while (q.size() != 0 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check("drain", q.size(), 32'd0);
        if (q.size() != 0) q.delete();
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rd_i[d] = 1'b0; wr_i[d] = 1'b0; addr_i[d] = 16'h0; din_i[d] = 16'h0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_dout",  {16'd0, dout_o[d]}, 32'd0);
            check("rst_done",  {31'd0, done_o[d]}, 32'd0);
            check("rst_stall", {31'd0, stall_o[d]}, 32'd0);
            check("rst_err",   {31'd0, err_o[d]}, 32'd0);
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Preload words later reloaded
        issue(0, 0, 1, 16'h0020, 16'h0000, 0);
        issue(0, 0, 1, 16'h0042, 16'h7777, 0);

        // Store then load
        issue(0, 0, 1, 16'h0010, 16'hBEEF, 0);
        issue(0, 1, 0, 16'h0010, 16'h0000, 0);

        // Illegal requests, then reload affected words
        issue(0, 1, 1, 16'h0010, 16'hDEAD, 0);
        issue(0, 1, 0, 16'h0011, 16'h0000, 0);
        issue(0, 0, 1, 16'h0043, 16'hDEAD, 0);
        issue(0, 1, 0, 16'h0010, 16'h0000, 0);
        issue(0, 1, 0, 16'h0042, 16'h0000, 0);

        // LATENCY=1 back-to-back alternating store/load
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) issue(1, 0, 1, (i % 4 >= 2) ? 16'h0002 : 16'h0000, 16'hA000 + 16'(i), 0);
            else            issue(1, 1, 0, (i % 4 >= 2) ? 16'h0002 : 16'h0000, 16'h0000, 0);
        end

        // Request inputs changing during BUSY
        issue(0, 0, 1, 16'h0040, 16'hCAFE, 1);
        issue(0, 1, 0, 16'h0040, 16'h0000, 0);
        issue(0, 1, 0, 16'h0042, 16'h0000, 0);

        // Reset during a store
        addr_i[0] = 16'h0020; din_i[0] = 16'h1234; wr_i[0] = 1'b1;
        @(negedge clk);
        check("rst_mid_stall_pre", {31'd0, stall_o[0]}, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        wr_i[0] = 1'b0;
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            check("rstm_dout",  {16'd0, dout_o[d]}, 32'd0);
            check("rstm_done",  {31'd0, done_o[d]}, 32'd0);
            check("rstm_stall", {31'd0, stall_o[d]}, 32'd0);
            check("rstm_err",   {31'd0, err_o[d]}, 32'd0);
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        issue(0, 1, 0, 16'h0020, 16'h0000, 0);

        // Maximum latency with address wrap onto word 0
        issue(2, 0, 1, 16'h0000, 16'h1111, 0);
        issue(2, 0, 1, 16'hF800, 16'h5A5A, 0);
        issue(2, 1, 0, 16'h0000, 16'h0000, 0);

        repeat (3) @(posedge clk);
        check("final_queue", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_resp.md
# data_mem_resp

Multi-cycle data-memory responder for the MEM stage of the five-stage pipeline. It accepts one load or store per transaction from the MEM stage, completes the access after a fixed, parameterised latency, and drives `Stall`. The hazard logic turns `Stall` into `dataMemStall` and deasserts `en` on the pipeline registers. It is the responder end of the interface whose initiator is the MEM stage feeding the MEM/WB register.

## Interface
- `LATENCY`, default 4: cycles from request acceptance to `Done`; legal range 1..15.
- `AW`, default 10: log2 of memory depth in 16-bit words.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-low. Asserting it clears the FSM, the counter and all outputs immediately.
- `Addr` input 16: byte address. Bit 0 must be 0. The word index is `Addr[AW:1]`; higher bits are ignored.
- `DataIn` input 16: store data.
- `Rd` input 1: load request.
- `Wr` input 1: store request.
- `DataOut` output 16: load data. Valid only while `Done` is high.
- `Done` output 1: one-cycle pulse marking transaction completion.
- `Stall` output 1: high while a transaction is in flight and not yet done.
- `Err` output 1: one-cycle pulse on an illegal request.

## Operation
- **States.** The FSM has three states: `IDLE`, `BUSY` and `DONE`. A 4-bit down-counter `cnt` runs alongside it.
- **IDLE.**
  - Exactly one of `Rd`/`Wr` high with `Addr[0]=0`: the request is accepted. Latch `Addr`, `DataIn` and `op`.
    - `LATENCY=1`: go to `DONE`.
    - Otherwise: load `cnt = LATENCY-1` and go to `BUSY`.
  - `Rd&Wr` high, or `Addr[0]=1` with either request high: pulse `Err` on the next cycle. No access occurs and the FSM stays in `IDLE`.
  - Neither request high: stay in `IDLE`.
- **BUSY.** Decrement `cnt` each cycle. When `cnt==1`, go to `DONE`. Request inputs are ignored; the initiator holds them stable because it is frozen.
- **DONE.**
  - Store: write the latched data into `mem[idx]` at the clock edge that ends `DONE`.
  - Load: `DataOut = mem[idx]`, registered so that it is valid throughout `DONE`.
  - Always return to `IDLE` next. Back-to-back requests therefore start no sooner than the cycle after `Done`.
- **Stall.** `Stall = (IDLE & accepted-request-present) | BUSY`. It is combinational from `Rd`/`Wr`/`Addr[0]` in `IDLE`, so the pipeline freezes in the request cycle itself. `Stall` is low in `DONE`, which lets MEM/WB capture `DataOut` at that edge.
- **Memory array.** Contents are not reset and are undefined at power-up. Only a store commit in `DONE` modifies them.
- **Reset mid-transaction.** Go to `IDLE` and abandon the transaction. A pending store is not committed.
- **Reset values.** `DataOut=0`, `Done=0`, `Err=0`, `Stall=0` (in `IDLE` with `Rd=Wr=0`), state `IDLE`, `cnt=0`.

## Timing
- A request is accepted in cycle T. `Done` is high in cycle T+`LATENCY`, and `Stall` is high in cycles T..T+`LATENCY`-1.
- `Err` is high only in cycle T+1. `Stall` is never asserted for an erroring request.
- A store's data is visible to a load accepted in cycle T+`LATENCY`+1 or later.
- No combinational path runs from `DataIn` to any output. `Stall` depends combinationally on `Rd`, `Wr`, `Addr[0]` and the state only.

## Structure
- Shared package `mem_pkg`:
  - State encoding: `IDLE=2'd0`, `BUSY=2'd1`, `DONE=2'd2`.
  - Word width 16.
  - The `LATENCY` legality check.
- Sub-module `dmem_array`: a synchronous single-port array with registered read, write enable and `AW`-bit index, instantiated once.
- The top level holds the FSM, the counter, the request latches and the output flops. It uses the team's `dffr` style of async-reset registers, with reset polarity per this spec.

## Test plan
- **Store then load, `LATENCY=4`.** Wr `Addr=0x0010` `DataIn=0xBEEF` at T. Then Rd `Addr=0x0010` at T+5. Expect `Stall` high T..T+3, `Done` at T+4, `Done` at T+9 with `DataOut=0xBEEF`.
- **Illegal requests.** Rd&Wr high at T, then Rd with `Addr=0x0011` at T+2. Expect `Err` at T+1 and T+3, `Stall` never high, and memory unchanged on a reload of the relevant words.
- **`LATENCY=1` back-to-back.** Alternate Wr and Rd to `0x0000` and `0x0002` every 2 cycles. Expect `Done` every second cycle and correct read data.
- **Reset during store.** Wr `Addr=0x0020` `DataIn=0x1234` at T. Pulse `rst` low at T+2. Expect all outputs 0 immediately. A later load of `0x0020` returns its prior value (`0x0000` if preloaded so), not `0x1234`.
- **Request held during BUSY.** Change `Addr` and `DataIn` at T+1..T+3. The store commits the values latched at T.
- **Maximum latency and word wrap.** `LATENCY=15` with `Addr=0xF800`, `AW=10` (index 0). Expect `Stall` for exactly 15 cycles, and the write alias-hits word 0.
